atm_pin_entry: RTL and testbench

//   Terminal-side PIN entry sequencer for the ATM datapath. Collects keypad digits,

---
 rtl/atm_pin_entry.sv | 198 +++++++++++++++++++
 tb/tb_atm_pin_entry.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_entry.sv
// -----------------------------------------------------------------------------
// atm_pin_entry
//   Terminal-side PIN entry sequencer. Collects keypad digits, offers the packed
//   PIN to the PIN comparator (pin_valid held until cmp_done), consumes the
//   compare result and decides between session grant, retry, or card eject
//   (retry limit or inactivity).
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   card_in         card present level; dropping it aborts any session
//   key_valid       one-cycle key strobe qualifying key_code
//   key_code        0-9 digit, 0xA clear, 0xB enter, 0xC-0xF ignored
//   pin_out         packed BCD PIN, first digit in the most significant nibble
//   pin_valid       request to the comparator, held until cmp_done
//   cmp_done        comparator response strobe
//   cmp_match       compare result, qualified by cmp_done
//   session_ok      PIN accepted (level)
//   eject_tries     eject because the retry limit was reached (level)
//   eject_timeout   eject because of inactivity (level)
//   tries_left      remaining wrong-PIN attempts
//   digit_count     digits currently entered
//   tempo           TIMEOUT_CYC minus idle count while timing, else 0
// -----------------------------------------------------------------------------
module atm_pin_entry #(
  parameter int DIGITS      = 4,    // 2..7
  parameter int MAX_TRIES   = 3,    // 1..7
  parameter int TIMEOUT_CYC = 300   // 1..511
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  card_in,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   pin_out,
  output logic                  pin_valid,
  input  logic                  cmp_done,
  input  logic                  cmp_match,
  output logic                  session_ok,
  output logic                  eject_tries,
  output logic                  eject_timeout,
  output logic [2:0]            tries_left,
  output logic [2:0]            digit_count,
  output logic [8:0]            tempo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_WAIT,
    S_GRANTED,
    S_EJECT
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [2:0] DIGITS_L  = 3'(DIGITS);
  localparam logic [2:0] TRIES_L   = 3'(MAX_TRIES);
  localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT_CYC);

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  pin_q, pin_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           tries_q, tries_d;
  logic [8:0]           idle_q, idle_d;
  logic                 ej_tries_q, ej_tries_d;
  logic                 ej_to_q, ej_to_d;

  logic [8:0]           idle_inc;
  logic                 expire;
  logic                 is_digit;

  // Saturating idle count; expiry is flagged on the edge where the count
  // would reach TIMEOUT_CYC, so the eject flag and tempo=0 appear together.
  assign idle_inc = (idle_q == TIMEOUT_L) ? idle_q : idle_q + 9'd1;
  assign expire   = (idle_inc == TIMEOUT_L);
  assign is_digit = (key_code <= 4'd9);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pin_d      = pin_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    idle_d     = idle_q;
    ej_tries_d = ej_tries_q;
    ej_to_d    = ej_to_q;

    if (state_q != S_IDLE && !card_in) begin
      // Card pulled: abort from anywhere and return to reset values.
      state_d    = S_IDLE;
      pin_d      = '0;
      cnt_d      = '0;
      tries_d    = TRIES_L;
      idle_d     = '0;
      ej_tries_d = 1'b0;
      ej_to_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (card_in) begin
            state_d = S_ENTRY;
            pin_d   = '0;
            cnt_d   = '0;
            tries_d = TRIES_L;
            idle_d  = '0;
          end
        end

        S_ENTRY: begin
          if (key_valid) begin
            // Any strobe, even an ignored code, counts as activity.
            idle_d = '0;
            if (is_digit) begin
              if (cnt_q < DIGITS_L) begin
                pin_d = {pin_q[4*DIGITS-5:0], key_code};
                cnt_d = cnt_q + 3'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              pin_d = '0;
              cnt_d = '0;
            end else if (key_code == KEY_ENTER && cnt_q == DIGITS_L) begin
              state_d = S_WAIT;
            end
          end else if (expire) begin
            state_d = S_EJECT;
            ej_to_d = 1'b1;
            idle_d  = idle_inc;
          end else begin
            idle_d = idle_inc;
          end
        end

        S_WAIT: begin
          // cmp_done takes priority over a same-cycle expiry.
          if (cmp_done) begin
            if (cmp_match) begin
              state_d = S_GRANTED;
            end else if (tries_q > 3'd1) begin
              state_d = S_ENTRY;
              tries_d = tries_q - 3'd1;
              pin_d   = '0;
              cnt_d   = '0;
              idle_d  = '0;
            end else begin
              state_d    = S_EJECT;
              tries_d    = '0;
              ej_tries_d = 1'b1;
            end
          end else if (expire) begin
            state_d = S_EJECT;
            ej_to_d = 1'b1;
            idle_d  = idle_inc;
          end else begin
            idle_d = idle_inc;
          end
        end

        // GRANTED and EJECT hold until the card is removed.
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pin_q      <= '0;
      cnt_q      <= '0;
      tries_q    <= TRIES_L;
      idle_q     <= '0;
      ej_tries_q <= 1'b0;
      ej_to_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pin_q      <= pin_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      idle_q     <= idle_d;
      ej_tries_q <= ej_tries_d;
      ej_to_q    <= ej_to_d;
    end
  end

  // Outputs are decoded from registers only, so each changes on the edge
  // after its cause.
  assign pin_out       = pin_q;
  assign pin_valid     = (state_q == S_WAIT);
  assign session_ok    = (state_q == S_GRANTED);
  assign eject_tries   = ej_tries_q;
  assign eject_timeout = ej_to_q;
  assign tries_left    = tries_q;
  assign digit_count   = cnt_q;
  assign tempo         = (state_q == S_ENTRY || state_q == S_WAIT) ? (TIMEOUT_L - idle_q) : 9'd0;

endmodule

// File: tb/tb_atm_pin_entry.sv
// -----------------------------------------------------------------------------
// tb_atm_pin_entry
//   Self-checking bench for atm_pin_entry. A session-level reference model
//   (digit queue, retry count, idle count) predicts every output each cycle and
//   pushes the expected comparator requests, grants and ejects into a
//   scoreboard queue; a monitor pops that queue whenever the DUT raises one of
//   those outputs.
// -----------------------------------------------------------------------------
module tb_atm_pin_entry;

  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] pin_out;
  logic        pin_valid;
  logic        cmp_done;
  logic        cmp_match;
  logic        session_ok;
  logic        eject_tries;
  logic        eject_timeout;
  logic [2:0]  tries_left;
  logic [2:0]  digit_count;
  logic [8:0]  tempo;

  atm_pin_entry #(
    .DIGITS      (DIGITS),
    .MAX_TRIES   (MAX_TRIES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .card_in       (card_in),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .pin_out       (pin_out),
    .pin_valid     (pin_valid),
    .cmp_done      (cmp_done),
    .cmp_match     (cmp_match),
    .session_ok    (session_ok),
    .eject_tries   (eject_tries),
    .eject_timeout (eject_timeout),
    .tries_left    (tries_left),
    .digit_count   (digit_count),
    .tempo         (tempo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_ENTRY, P_WAIT, P_GRANTED, P_EJECT} phase_t;
  typedef enum {EV_REQ, EV_GRANT, EV_EJ_TRIES, EV_EJ_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] val;
  } ev_t;

  phase_t m_phase;
  int     m_digits[$];
  int     m_tries;
  int     m_idle;
  bit     m_ej_tries;
  bit     m_ej_to;
  ev_t    exp_q[$];

  function automatic logic [15:0] model_pin();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return 16'(v);
  endfunction

  function automatic void push_ev(ev_kind_t k, logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_phase    = P_IDLE;
    m_digits.delete();
    m_tries    = MAX_TRIES;
    m_idle     = 0;
    m_ej_tries = 0;
    m_ej_to    = 0;
  endfunction

  // One idle cycle of the inactivity timer; returns 1 when it expires.
  function automatic bit model_tick_idle();
    m_idle++;
    if (m_idle >= TIMEOUT_CYC) begin
      m_phase = P_EJECT;
      m_ej_to = 1;
      push_ev(EV_EJ_TIMEOUT, 16'h0);
      return 1;
    end
    return 0;
  endfunction

  // Outcome of the clock edge that samples the given inputs.
  function automatic void model_step(bit card, bit kv, int kc, bit done, bit match);
    bit unused;
    if (m_phase == P_IDLE) begin
      if (card) begin
        model_reset();
        m_phase = P_ENTRY;
      end
      return;
    end
    if (!card) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_ENTRY: begin
        if (kv) begin
          m_idle = 0;
          if (kc <= 9) begin
            if (m_digits.size() < DIGITS) m_digits.push_back(kc);
          end else if (kc == 10) begin
            m_digits.delete();
          end else if (kc == 11 && m_digits.size() == DIGITS) begin
            m_phase = P_WAIT;
            push_ev(EV_REQ, model_pin());
          end
        end else begin
          unused = model_tick_idle();
        end
      end
      P_WAIT: begin
        if (done) begin
          if (match) begin
            m_phase = P_GRANTED;
            push_ev(EV_GRANT, 16'h0);
          end else if (m_tries > 1) begin
            m_tries--;
            m_digits.delete();
            m_idle  = 0;
            m_phase = P_ENTRY;
          end else begin
            m_tries    = 0;
            m_ej_tries = 1;
            m_phase    = P_EJECT;
            push_ev(EV_EJ_TRIES, 16'h0);
          end
        end else begin
          unused = model_tick_idle();
        end
      end
      default: ;
    endcase
  endfunction

  task automatic compare_all();
    bit timing;
    timing = (m_phase == P_ENTRY || m_phase == P_WAIT);
    check("pin_out",     32'(pin_out),     32'(model_pin()));
    check("flags",       {28'h0, pin_valid, session_ok, eject_tries, eject_timeout},
                         {28'h0, m_phase == P_WAIT, m_phase == P_GRANTED, m_ej_tries, m_ej_to});
    check("tries_left",  32'(tries_left),  32'(m_tries));
    check("digit_count", 32'(digit_count), 32'(m_digits.size()));
    check("tempo",       32'(tempo),       timing ? 32'(TIMEOUT_CYC - m_idle) : 32'h0);
  endtask

  // ---------------- stimulus helpers ----------------
  bit card_lvl = 0;

  task automatic cycle(input bit kv, input int kc, input bit done, input bit match);
    card_in   = card_lvl;
    key_valid = kv;
    key_code  = 4'(kc);
    cmp_done  = done;
    cmp_match = match;
    model_step(card_lvl, kv, kc, done, match);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic press(input int k);
    cycle(1, k, 0, 0);
  endtask

  task automatic respond(input bit match);
    cycle(0, 0, 1, match);
  endtask

  task automatic card(input bit lvl);
    card_lvl = lvl;
    cycle(0, 0, 0, 0);
  endtask

  task automatic enter_pin(input int d0, input int d1, input int d2, input int d3);
    press(d0); press(d1); press(d2); press(d3); press(11);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic pv_prev = 0, ok_prev = 0, et_prev = 0, eto_prev = 0;

  task automatic pop_cmp(input ev_kind_t k, input logic [15:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 32'(k), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(k), 32'(e.kind));
      check("sb_value", 32'(v), 32'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pin_valid && !pv_prev)       pop_cmp(EV_REQ, pin_out);
      if (session_ok && !ok_prev)      pop_cmp(EV_GRANT, 16'h0);
      if (eject_tries && !et_prev)     pop_cmp(EV_EJ_TRIES, 16'h0);
      if (eject_timeout && !eto_prev)  pop_cmp(EV_EJ_TIMEOUT, 16'h0);
    end
    pv_prev  = pin_valid;
    ok_prev  = session_ok;
    et_prev  = eject_tries;
    eto_prev = eject_timeout;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 0; card_in = 0; key_valid = 0; key_code = 0; cmp_done = 0; cmp_match = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;

    // 1: correct PIN accepted, request held until done.
    card(1);
    enter_pin(1, 2, 3, 4);
    check("t1_pin_out", 32'(pin_out), 32'h1234);
    idle(1);
    check("t1_pin_valid_held", 32'(pin_valid), 32'h1);
    respond(1);
    check("t1_session_ok", 32'(session_ok), 32'h1);
    idle(2);
    card(0);

    // 2: three wrong attempts -> retained-card eject.
    card(1);
    for (int a = 0; a < MAX_TRIES; a++) begin
      check("t2_tries_before", 32'(tries_left), 32'(MAX_TRIES - a));
      enter_pin(9, 9, 9, 9);
      idle(1);
      respond(0);
    end
    check("t2_eject_tries", 32'(eject_tries), 32'h1);
    idle(3);
    card(0);
    check("t2_back_idle_tries", 32'(tries_left), 32'(MAX_TRIES));

    // 3: clear, 5th digit ignored, short enter ignored.
    card(1);
    press(5); press(6); press(10);
    press(7); press(8); press(9);
    press(11);
    check("t3_short_enter", 32'(pin_valid), 32'h0);
    press(0); press(1);
    check("t3_fifth_digit", 32'(pin_out), 32'h7890);
    press(11);
    check("t3_request_pin", 32'(pin_out), 32'h7890);
    press(4);
    respond(0);
    card(0);

    // 4: inactivity; an ignored key one cycle before expiry restarts the count.
    card(1);
    idle(TIMEOUT_CYC - 1);
    press(12);
    idle(TIMEOUT_CYC - 1);
    check("t4_no_early_eject", 32'(eject_timeout), 32'h0);
    idle(1);
    check("t4_eject_at_expiry", 32'(eject_timeout), 32'h1);
    check("t4_tempo_zero", 32'(tempo), 32'h0);
    idle(3);
    card(0);

    // 5: cmp_done on the expiry cycle wins; card pulled during WAIT.
    card(1);
    enter_pin(4, 3, 2, 1);
    for (int i = 0; i < 2 * TIMEOUT_CYC && m_idle < TIMEOUT_CYC - 1; i++) idle(1);
    check("t5_at_last_cycle", 32'(tempo), 32'h1);
    respond(1);
    check("t5_granted", 32'(session_ok), 32'h1);
    check("t5_no_eject", 32'(eject_timeout), 32'h0);
    card(0);
    card(1);
    enter_pin(1, 1, 1, 1);
    idle(2);
    card(0);
    check("t5_abort_pin_valid", 32'(pin_valid), 32'h0);

    // 6: asynchronous reset in the middle of entry.
    card(1);
    press(3); press(7);
    rst_n = 0;
    #2;
    model_reset();
    check("t6_async_digits", 32'(digit_count), 32'h0);
    compare_all();
    rst_n = 1;

    // 7: randomized sessions.
    for (int i = 0; i < 4000; i++) begin
      int  r;
      int  kc;
      bit  kv;
      bit  done;
      r = int'($urandom_range(0, 99));
      if (m_phase == P_GRANTED || m_phase == P_EJECT) card_lvl = (r >= 10);
      else if (m_phase == P_IDLE) card_lvl = (r >= 30);
      else card_lvl = (r != 0);
      kv = ($urandom_range(0, 2) == 0);
      r  = int'($urandom_range(0, 99));
      if (m_phase == P_ENTRY && m_digits.size() == DIGITS && r < 40) kc = 11;
      else if (r < 75) kc = int'($urandom_range(0, 9));
      else kc = int'($urandom_range(10, 15));
      done = (m_phase == P_WAIT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cycle(kv, kc, done, 1'($urandom_range(0, 1)));
    end

    card(0);
    idle(2);
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
